sumu3_arb: RTL and testbench
============================

SUMU3_ARB -- requirements
Module: sumu3_arb

Interface
REQ-001 Parameter LAT, default 1, legal 1..7: clock edges from operand issue to result capture on the shared sumu3 datapath.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req0/req1  in  1  request from requester 0/1; held high with operands stable until the matching grant.
REQ-005 a0/a1  in  3, b0/b1  in  3, sl0/sl1  in  2  operands and op select of requester 0/1.
REQ-006 gnt0/gnt1  out  1  one-cycle grant pulse to requester 0/1.
REQ-007 op_a  out  3, op_b  out  3, op_sl  out  2  registered operands to the shared sumu3 instance.
REQ-008 op_c  in  7  result returned by the sumu3 instance.
REQ-009 rsp_valid  out  1, rsp_id  out  1, rsp_c  out  7  response valid, served requester, captured result.
REQ-010 rsp_ready  in  1  response consumer ready.
REQ-011 busy  out  1  high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, EXEC, RESP; exactly one active.
REQ-013 IDLE: at an edge with req0|req1 high, the block SHALL select a winner, load op_a/op_b/op_sl from the winner, load the latency counter with LAT-1, go to EXEC, and assert that requester's gnt for exactly the following cycle.
REQ-014 Arbitration: a single requester SHALL win regardless of priority; with both high, the requester named by pointer prio SHALL win.
REQ-015 After each response handshake prio SHALL become the other requester than the one served (round-robin).
REQ-016 EXEC: at each edge, if the counter is 0 the block SHALL capture op_c into rsp_c, set rsp_valid and rsp_id, and go to RESP; otherwise decrement the counter.
REQ-017 rsp_valid SHALL rise exactly LAT edges after the grant edge.
REQ-018 RESP: rsp_valid, rsp_id, rsp_c SHALL hold stable until an edge with rsp_ready high; then rsp_valid drops, state returns to IDLE.
REQ-019 req inputs SHALL be ignored in EXEC and RESP; a request still high on return to IDLE is a new request.
REQ-020 Minimum issue-to-issue spacing SHALL be LAT+2 cycles with rsp_ready tied high.
REQ-021 op_a/op_b/op_sl SHALL hold their last issued values outside the issue edge.
REQ-022 rsp_ready high while rsp_valid is low SHALL have no effect.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, prio=0, gnt0=gnt1=0, rsp_valid=0, rsp_id=0, rsp_c=0, op_a=op_b=0, op_sl=0, busy=0.
REQ-024 Reset in EXEC or RESP SHALL discard the in-flight operation with no response.
REQ-025 The first request after reset release SHALL be sampled no earlier than the first rising edge with rst_n high.

Configuration
REQ-026 With SUMU3_ARB_STATS_EN defined, output ports cnt0 and cnt1 (out, 8) SHALL exist and count completed response handshakes per requester, saturating at 255, reset to 0.
REQ-027 Without SUMU3_ARB_STATS_EN, cnt0/cnt1 and their logic SHALL be absent and all other behaviour identical.

Verification
REQ-028 LAT=1, req0 with a0=4, b0=1, sl0=3, stub op_c=7'd5, rsp_ready=1 -> gnt0 one cycle; op_a=4, op_b=1, op_sl=3; rsp_valid one edge later with rsp_id=0, rsp_c=5.
REQ-029 After reset, req0 and req1 high on the same edge -> requester 0 served first; requester 1 served on the next IDLE; a third simultaneous request goes to 0.
REQ-030 LAT=3, rsp_ready held low 5 cycles -> rsp_valid rises 3 edges after the grant edge; rsp_c stays stable for all 5 cycles; busy high throughout; IDLE after ready.
REQ-031 rst_n pulsed low during EXEC -> all outputs reach reset values immediately; no rsp_valid follows; the next request is granted normally.
REQ-032 STATS build: 300 served requests from requester 1 -> cnt1=255, cnt0=0.
REQ-033 req1 held high continuously with req0 idle -> back-to-back grants to 1 spaced LAT+2 cycles apart.

Source files
------------

// File: rtl/sumu3_arb.sv
// Two-requester round-robin arbiter in front of a shared sumu3 datapath with LAT-cycle result latency.
// Optional per-requester handshake counters are compiled in with SUMU3_ARB_STATS_EN.
module sumu3_arb #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] a0,
    input  logic [2:0] b0,
    input  logic [1:0] sl0,
    input  logic [2:0] a1,
    input  logic [2:0] b1,
    input  logic [1:0] sl1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [2:0] op_a,
    output logic [2:0] op_b,
    output logic [1:0] op_sl,
    input  logic [6:0] op_c,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [6:0] rsp_c,
    input  logic       rsp_ready,
    output logic       busy
`ifdef SUMU3_ARB_STATS_EN
    ,
    output logic [7:0] cnt0,
    output logic [7:0] cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(LAT - 1);

    state_t     state_r, state_s;
    logic [2:0] lat_cnt_r;
    logic       prio_r, id_r;
    logic       gnt0_r, gnt1_r, busy_r;
    logic [2:0] op_a_r, op_b_r;
    logic [1:0] op_sl_r;
    logic       rsp_valid_r, rsp_id_r;
    logic [6:0] rsp_c_r;
    logic       issue_s, win_s, capture_s, done_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode, winner selection and per-edge action strobes
    always_comb begin
        state_s   = state_r;
        issue_s   = 1'b0;
        capture_s = 1'b0;
        done_s    = 1'b0;
        if (req0 && req1) begin
            win_s = prio_r;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    state_s = EXEC;
                    issue_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                if (lat_cnt_r == 3'd0) begin
                    state_s   = RESP;
                    capture_s = 1'b1;
                end else begin
                    state_s = EXEC;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Grant pulses, operand issue, latency count, response capture and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            busy_r      <= 1'b0;
            op_a_r      <= 3'd0;
            op_b_r      <= 3'd0;
            op_sl_r     <= 2'd0;
            id_r        <= 1'b0;
            lat_cnt_r   <= 3'd0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_c_r     <= 7'd0;
            prio_r      <= 1'b0;
        end else begin
            gnt0_r <= issue_s & ~win_s;
            gnt1_r <= issue_s & win_s;
            busy_r <= (state_s != IDLE);
            if (issue_s) begin
                op_a_r    <= win_s ? a1 : a0;
                op_b_r    <= win_s ? b1 : b0;
                op_sl_r   <= win_s ? sl1 : sl0;
                id_r      <= win_s;
                lat_cnt_r <= LAT_M1;
            end else if ((state_r == EXEC) && !capture_s) begin
                lat_cnt_r <= lat_cnt_r - 3'd1;
            end
            if (capture_s) begin
                rsp_valid_r <= 1'b1;
                rsp_id_r    <= id_r;
                rsp_c_r     <= op_c;
            end else if (done_s) begin
                rsp_valid_r <= 1'b0;
                prio_r      <= ~rsp_id_r;
            end
        end
    end

    assign gnt0      = gnt0_r;
    assign gnt1      = gnt1_r;
    assign busy      = busy_r;
    assign op_a      = op_a_r;
    assign op_b      = op_b_r;
    assign op_sl     = op_sl_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_c     = rsp_c_r;

`ifdef SUMU3_ARB_STATS_EN
    logic [7:0] cnt0_r, cnt1_r;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'd255) ? v : v + 8'd1;
    endfunction

    // Completed-handshake counters, saturating at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_r <= 8'd0;
            cnt1_r <= 8'd0;
        end else if (done_s) begin
            if (rsp_id_r) begin
                cnt1_r <= sat_inc(cnt1_r);
            end else begin
                cnt0_r <= sat_inc(cnt0_r);
            end
        end
    end

    assign cnt0 = cnt0_r;
    assign cnt1 = cnt1_r;
`endif

endmodule

// File: tb/tb_sumu3_arb.sv
// Directed bench for sumu3_arb: one LAT=1 and one LAT=3 instance share the input stimulus.
module tb_sumu3_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, rsp_ready = 1'b0;
    logic [2:0] a0 = 3'd0, b0 = 3'd0, a1 = 3'd0, b1 = 3'd0;
    logic [1:0] sl0 = 2'd0, sl1 = 2'd0;
    logic [6:0] op_c = 7'd0;

    logic       g0_1, g1_1, rv_1, rid_1, bz_1;
    logic [2:0] oa_1, ob_1;
    logic [1:0] os_1;
    logic [6:0] rc_1;
    logic       g0_3, g1_3, rv_3, rid_3, bz_3;
    logic [2:0] oa_3, ob_3;
    logic [1:0] os_3;
    logic [6:0] rc_3;
`ifdef SUMU3_ARB_STATS_EN
    logic [7:0] c0_1, c1_1, c0_3, c1_3;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    sumu3_arb #(.LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .sl0(sl0), .a1(a1), .b1(b1), .sl1(sl1),
        .gnt0(g0_1), .gnt1(g1_1), .op_a(oa_1), .op_b(ob_1), .op_sl(os_1),
        .op_c(op_c), .rsp_valid(rv_1), .rsp_id(rid_1), .rsp_c(rc_1),
        .rsp_ready(rsp_ready), .busy(bz_1)
`ifdef SUMU3_ARB_STATS_EN
        , .cnt0(c0_1), .cnt1(c1_1)
`endif
    );

    sumu3_arb #(.LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .sl0(sl0), .a1(a1), .b1(b1), .sl1(sl1),
        .gnt0(g0_3), .gnt1(g1_3), .op_a(oa_3), .op_b(ob_3), .op_sl(os_3),
        .op_c(op_c), .rsp_valid(rv_3), .rsp_id(rid_3), .rsp_c(rc_3),
        .rsp_ready(rsp_ready), .busy(bz_3)
`ifdef SUMU3_ARB_STATS_EN
        , .cnt0(c0_3), .cnt1(c1_3)
`endif
    );

    typedef struct {
        logic       r0, r1;
        logic [6:0] c;
        logic       rdy;
        logic       g0, g1;
        logic [2:0] oa, ob;
        logic [1:0] os;
        logic       rv, rid;
        logic [6:0] rc;
        logic       bz;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset both instances, check u1 reset values, release on a falling edge
    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0; rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        chk("rst_gnt0", int'(g0_1), 0);
        chk("rst_gnt1", int'(g1_1), 0);
        chk("rst_op_a", int'(oa_1), 0);
        chk("rst_op_b", int'(ob_1), 0);
        chk("rst_op_sl", int'(os_1), 0);
        chk("rst_rsp_valid", int'(rv_1), 0);
        chk("rst_rsp_id", int'(rid_1), 0);
        chk("rst_rsp_c", int'(rc_1), 0);
        chk("rst_busy", int'(bz_1), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int last1, last3, n1, n3;

        //          r0    r1    c      rdy  | g0    g1    oa    ob    os    rv    rid   rc     bz
        tbl[0]  = '{1'b1, 1'b1, 7'd5, 1'b1, 1'b1, 1'b0, 3'd4, 3'd1, 2'd3, 1'b0, 1'b0, 7'd0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 7'd5, 1'b1, 1'b0, 1'b0, 3'd4, 3'd1, 2'd3, 1'b1, 1'b0, 7'd5, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 7'd5, 1'b1, 1'b0, 1'b0, 3'd4, 3'd1, 2'd3, 1'b0, 1'b0, 7'd5, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 7'd9, 1'b1, 1'b0, 1'b1, 3'd6, 3'd2, 2'd1, 1'b0, 1'b0, 7'd5, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 7'd9, 1'b1, 1'b0, 1'b0, 3'd6, 3'd2, 2'd1, 1'b1, 1'b1, 7'd9, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 7'd9, 1'b1, 1'b0, 1'b0, 3'd6, 3'd2, 2'd1, 1'b0, 1'b1, 7'd9, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 7'd3, 1'b0, 1'b1, 1'b0, 3'd4, 3'd1, 2'd3, 1'b0, 1'b1, 7'd9, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 7'd3, 1'b0, 1'b0, 1'b0, 3'd4, 3'd1, 2'd3, 1'b1, 1'b0, 7'd3, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 7'd7, 1'b0, 1'b0, 1'b0, 3'd4, 3'd1, 2'd3, 1'b1, 1'b0, 7'd3, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 7'd7, 1'b1, 1'b0, 1'b0, 3'd4, 3'd1, 2'd3, 1'b0, 1'b0, 7'd3, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 7'd7, 1'b1, 1'b0, 1'b0, 3'd4, 3'd1, 2'd3, 1'b0, 1'b0, 7'd3, 1'b0};

        // LAT=1 table: simultaneous requests, round-robin, response hold, idle ready
        do_reset();
        a0 = 3'd4; b0 = 3'd1; sl0 = 2'd3;
        a1 = 3'd6; b1 = 3'd2; sl1 = 2'd1;
        for (int i = 0; i < 11; i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1; op_c = tbl[i].c; rsp_ready = tbl[i].rdy;
            step();
            chk($sformatf("v%0d_gnt0", i), int'(g0_1), int'(tbl[i].g0));
            chk($sformatf("v%0d_gnt1", i), int'(g1_1), int'(tbl[i].g1));
            chk($sformatf("v%0d_op_a", i), int'(oa_1), int'(tbl[i].oa));
            chk($sformatf("v%0d_op_b", i), int'(ob_1), int'(tbl[i].ob));
            chk($sformatf("v%0d_op_sl", i), int'(os_1), int'(tbl[i].os));
            chk($sformatf("v%0d_rsp_valid", i), int'(rv_1), int'(tbl[i].rv));
            chk($sformatf("v%0d_rsp_id", i), int'(rid_1), int'(tbl[i].rid));
            chk($sformatf("v%0d_rsp_c", i), int'(rc_1), int'(tbl[i].rc));
            chk($sformatf("v%0d_busy", i), int'(bz_1), int'(tbl[i].bz));
        end

        // LAT=3 latency and response hold with rsp_ready low for 5 cycles
        do_reset();
        a0 = 3'd2; b0 = 3'd3; sl0 = 2'd2; op_c = 7'd17;
        req0 = 1'b1;
        step();
        chk("l3_gnt0", int'(g0_3), 1);
        chk("l3_op_a", int'(oa_3), 2);
        chk("l3_op_sl", int'(os_3), 2);
        req0 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("l3_rv_edge%0d", k), int'(rv_3), (k == 3) ? 1 : 0);
            chk($sformatf("l3_busy_edge%0d", k), int'(bz_3), 1);
            chk($sformatf("l3_gnt0_edge%0d", k), int'(g0_3), 0);
        end
        chk("l3_rsp_c", int'(rc_3), 17);
        chk("l3_rsp_id", int'(rid_3), 0);
        op_c = 7'd33;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("l3_hold_rv%0d", k), int'(rv_3), 1);
            chk($sformatf("l3_hold_c%0d", k), int'(rc_3), 17);
            chk($sformatf("l3_hold_busy%0d", k), int'(bz_3), 1);
        end
        rsp_ready = 1'b1;
        step();
        chk("l3_done_rv", int'(rv_3), 0);
        chk("l3_done_busy", int'(bz_3), 0);

        // Reset asserted mid-EXEC on the LAT=3 instance
        do_reset();
        rsp_ready = 1'b1;
        a1 = 3'd6; b1 = 3'd5; sl1 = 2'd2; op_c = 7'd44;
        req1 = 1'b1;
        step();
        chk("ar_gnt1", int'(g1_3), 1);
        req1 = 1'b0;
        step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", int'(bz_3), 0);
        chk("ar_op_a", int'(oa_3), 0);
        chk("ar_op_b", int'(ob_3), 0);
        chk("ar_op_sl", int'(os_3), 0);
        chk("ar_gnt1_low", int'(g1_3), 0);
        chk("ar_rsp_valid", int'(rv_3), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("ar_no_rsp%0d", k), int'(rv_3), 0);
        end
        req0 = 1'b1; req1 = 1'b1;
        step();
        chk("ar_regrant0", int'(g0_3), 1);
        chk("ar_regrant1", int'(g1_3), 0);
        req0 = 1'b0; req1 = 1'b0;

        // Continuous req1: back-to-back grants LAT+2 apart
        do_reset();
        rsp_ready = 1'b1;
        req1 = 1'b1;
        last1 = -1; last3 = -1; n1 = 0; n3 = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            step();
            if (g1_1) begin
                if (last1 >= 0) chk($sformatf("bb1_space@%0d", cyc), cyc - last1, 3);
                last1 = cyc;
                n1++;
            end
            if (g1_3) begin
                if (last3 >= 0) chk($sformatf("bb3_space@%0d", cyc), cyc - last3, 5);
                last3 = cyc;
                n3++;
            end
        end
        chk("bb1_count", n1, 14);
        chk("bb3_count", n3, 8);
        req1 = 1'b0;

`ifdef SUMU3_ARB_STATS_EN
        // Saturating handshake counters
        do_reset();
        chk("st_cnt1_rst", int'(c1_1), 0);
        rsp_ready = 1'b1;
        req1 = 1'b1;
        repeat (3 * 300 + 30) step();
        chk("st_cnt1", int'(c1_1), 255);
        chk("st_cnt0", int'(c0_1), 0);
        req1 = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
